// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: turns rising edges on N synchronized level inputs into
// per-channel pending events and serves them one at a time, round-robin,
// to a single handler over a valid/ready handshake.  Overflow is sticky.
module edge_event_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  din,
  input  logic [N-1:0]  en,
  output logic          evt_valid,
  output logic [IW-1:0] evt_id,
  input  logic          evt_ready,
  output logic [N-1:0]  pend,
  output logic [N-1:0]  ovf,
  input  logic          ovf_clr
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  logic [N-1:0]  din_d_r;
  logic [N-1:0]  rise_s;
  logic          accept_s;
  logic [N-1:0]  acc_mask_s;
  logic [N-1:0]  pend_nxt_s;
  logic [N-1:0]  ovf_nxt_s;
  logic [IW:0]   pick_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          valid_nxt_s;
  logic [IW-1:0] id_nxt_s;
  logic [IW-1:0] last_r;
  logic [IW-1:0] last_nxt_s;

  // Round-robin pick: first set bit searching from last+1 with wrap.
  // Result is {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] req,
                                          input logic [IW-1:0] last);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    int            c;
    res = {(IW+1){1'b0}};
    for (int k = 1; k <= N; k++) begin
      c = int'(last) + k;
      if (c >= N) begin
        c = c - N;
      end else begin
        c = c;
      end
      idx = IW'(c);
      if (!res[IW] && req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Edge detection plus next pending/overflow state; a rise on the channel
  // being accepted re-queues it instead of overflowing.
  always_comb begin
    acc_mask_s = {N{1'b0}};
    rise_s     = din & ~din_d_r & en;
    accept_s   = evt_valid & evt_ready;
    for (int i = 0; i < N; i++) begin
      acc_mask_s[i] = accept_s && (evt_id == IW'(i));
    end
    pend_nxt_s = rise_s | (pend & ~acc_mask_s);
    ovf_nxt_s  = (rise_s & pend & ~acc_mask_s) | (ovf & ~{N{ovf_clr}});
  end

  // Candidate channel for the next grant, taken from the registered pend.
  always_comb begin
    pick_s = rr_pick(pend, last_r);
  end

  // Grant FSM next-state and next-output logic.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = evt_valid;
    id_nxt_s    = evt_id;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_s[IW]) begin
          valid_nxt_s = 1'b1;
          id_nxt_s    = pick_s[IW-1:0];
          state_nxt_s = ST_GRANT;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_GRANT: begin
        if (evt_ready) begin
          valid_nxt_s = 1'b0;
          last_nxt_s  = evt_id;
          state_nxt_s = ST_IDLE;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Input history; also loaded during reset so a level already high at
  // reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    din_d_r <= din;
  end

  // State, handshake outputs and per-channel flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_id    <= {IW{1'b0}};
      last_r    <= IW'(N - 1);
      pend      <= {N{1'b0}};
      ovf       <= {N{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      evt_valid <= valid_nxt_s;
      evt_id    <= id_nxt_s;
      last_r    <= last_nxt_s;
      pend      <= pend_nxt_s;
      ovf       <= ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle to a behavioural model.
module tb_edge_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  din;
  logic [N-1:0]  en;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_ready;
  logic [N-1:0]  pend;
  logic [N-1:0]  ovf;
  logic          ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit [N-1:0] m_prev;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_ovf;
  bit         m_valid;
  int         m_id;
  int         m_last;
  int         acc_q[$];

  edge_event_arbiter #(.N(N), .IW(IW)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit [N-1:0] old_pend;
    bit         taken;
    if (rst) begin
      m_prev = din; m_pend = '0; m_ovf = '0;
      m_valid = 1'b0; m_id = 0; m_last = N - 1;
      return;
    end
    old_pend = m_pend;
    taken    = m_valid && evt_ready;
    for (int i = 0; i < N; i++) begin
      bit r, served;
      r      = din[i] && !m_prev[i] && en[i];
      served = taken && (m_id == i);
      if (ovf_clr) m_ovf[i] = 1'b0;
      if (r && old_pend[i] && !served) m_ovf[i] = 1'b1;
      m_pend[i] = r || (old_pend[i] && !served);
    end
    if (m_valid) begin
      if (evt_ready) begin
        m_valid = 1'b0;
        m_last  = m_id;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!m_valid && old_pend[c]) begin
          m_valid = 1'b1;
          m_id    = c;
        end
      end
    end
    m_prev = din;
  endtask

  // One clock: record handshakes, step model, compare outputs after the edge.
  task automatic tick();
    if (evt_valid === 1'b1 && evt_ready && !rst) acc_q.push_back(int'(evt_id));
    @(posedge clk);
    model_step();
    #1;
    check("evt_valid", evt_valid, m_valid);
    if (m_valid) check("evt_id", evt_id, m_id);
    check("pend", pend, m_pend);
    check("ovf", ovf, m_ovf);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; din = 4'b0101; en = 4'b1111; evt_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    // reset with levels already high: nothing should happen
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t1_valid", evt_valid, 1'b0);
    check("t1_pend", pend, 4'b0000);
    check("t1_ovf", ovf, 4'b0000);

    // single edge on ch2, one-cycle handshake
    evt_ready = 1'b1;
    din = 4'b0001; tick();
    din = 4'b0101; tick();
    check("t2_pend", pend, 4'b0100);
    tick();
    check("t2_valid", evt_valid, 1'b1);
    check("t2_id", evt_id, 2);
    tick();
    check("t2_pend_clr", pend, 4'b0000);
    check("t2_valid_clr", evt_valid, 1'b0);

    // simultaneous edges after reset: 0,1,2,3
    rst = 1'b1; din = 4'b0000; tick();
    rst = 1'b0; tick();
    acc_q.delete();
    din = 4'b1111;
    for (int i = 0; i < 10; i++) tick();
    check("t3_count", acc_q.size(), 4);
    if (acc_q.size() == 4)
      for (int i = 0; i < 4; i++) check("t3_order", acc_q[i], i);

    // overflow on ch1 while stalled
    evt_ready = 1'b0; din = 4'b0000; tick(); tick();
    din = 4'b0010; tick(); tick();
    din = 4'b0000; tick();
    din = 4'b0010; tick();
    check("t4_ovf", ovf, 4'b0010);
    evt_ready = 1'b1; acc_q.delete();
    for (int i = 0; i < 5; i++) tick();
    cnt = 0;
    foreach (acc_q[i]) if (acc_q[i] == 1) cnt++;
    check("t4_one_evt", cnt, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_clr", ovf, 4'b0000);

    // last=1 now: ch3 before ch0
    evt_ready = 1'b0; din = 4'b0000; tick();
    din = 4'b1001; tick(); tick();
    check("t5_first", evt_id, 3);
    evt_ready = 1'b1; acc_q.delete();
    for (int i = 0; i < 5; i++) tick();
    check("t5_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check("t5_a", acc_q[0], 3);
      check("t5_b", acc_q[1], 0);
    end

    // masked channel, then reset in the middle of a grant
    din = 4'b0000; en = 4'b0111; tick();
    din = 4'b1000; tick(); tick();
    check("t6_masked_pend", pend, 4'b0000);
    check("t6_masked_ovf", ovf, 4'b0000);
    en = 4'b1111; din = 4'b0000; evt_ready = 1'b0; tick();
    din = 4'b0010; tick(); tick();
    check("t6_grant", evt_valid, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_valid", evt_valid, 1'b0);
    check("t6_rst_pend", pend, 4'b0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      din       = N'($urandom);
      en        = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
      evt_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
